// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
// Carries the decoder's control bundle through the ID/EX, EX/MEM and MEM/WB
// pipeline registers. It detects load-use hazards and inserts one bubble for
// each. It squashes the two younger stages when a branch resolves taken in MEM.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_*              decoded control bundle and register fields from ID
//   mem_zero          ALU zero flag of the instruction in MEM
//   stall             hold PC and IF/ID this cycle (load-use hazard)
//   flush             clear IF/ID this cycle (taken branch)
//   ex_*              ID/EX register
//   mem_*             EX/MEM register (mem_dest is the resolved destination)
//   branch_taken      branch in MEM resolves taken
//   wb_*              MEM/WB register
//   stall_cnt         saturating count of stall cycles
//   flush_cnt         saturating count of flush cycles
module ctrl_pipe_hazard #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_regdst,
    input  logic              id_branch,
    input  logic              id_memread,
    input  logic              id_memtoreg,
    input  logic              id_memwrite,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic [1:0]        id_aluop,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              mem_zero,
    output logic              stall,
    output logic              flush,
    output logic              ex_valid,
    output logic              ex_regdst,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_valid,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_memtoreg,
    output logic              mem_regwrite,
    output logic              mem_branch,
    output logic [REG_AW-1:0] mem_dest,
    output logic              branch_taken,
    output logic              wb_valid,
    output logic              wb_memtoreg,
    output logic              wb_regwrite,
    output logic [REG_AW-1:0] wb_dest,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              hazard;
    logic              id_load;
    logic              ex_adv;
    logic [REG_AW-1:0] ex_dest;

    // A load in EX whose target feeds the ID instruction. r0 is never a real
    // dependency. A bubble in EX carries ex_rt=0, so it never matches.
    always_comb begin
        hazard = id_valid & ex_valid & ex_memread & (ex_rt != '0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

    assign branch_taken = mem_valid & mem_branch & mem_zero;
    assign flush        = branch_taken;
    // A taken branch kills the dependent instruction anyway, so it wins.
    assign stall        = hazard & ~branch_taken;

    assign id_load = id_valid & ~stall & ~flush;
    assign ex_adv  = ex_valid & ~flush;
    assign ex_dest = ex_regdst ? ex_rd : ex_rt;

    // ID/EX: take the decoded bundle, or a fully zeroed bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_rt       <= '0;
            ex_rd       <= '0;
        end else if (id_load) begin
            ex_valid    <= 1'b1;
            ex_regdst   <= id_regdst;
            ex_memread  <= id_memread;
            ex_memtoreg <= id_memtoreg;
            ex_memwrite <= id_memwrite;
            ex_alusrc   <= id_alusrc;
            ex_regwrite <= id_regwrite;
            ex_branch   <= id_branch;
            ex_aluop    <= id_aluop;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
        end else begin
            ex_valid    <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_rt       <= '0;
            ex_rd       <= '0;
        end
    end

    // EX/MEM: resolve the destination here. A write to r0 is dropped at this
    // point, so every later stage sees it as a non-writing instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid    <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_branch   <= 1'b0;
            mem_dest     <= '0;
        end else if (ex_adv) begin
            mem_valid    <= 1'b1;
            mem_memread  <= ex_memread;
            mem_memwrite <= ex_memwrite;
            mem_memtoreg <= ex_memtoreg;
            mem_regwrite <= ex_regwrite & (ex_dest != '0);
            mem_branch   <= ex_branch;
            mem_dest     <= ex_dest;
        end else begin
            mem_valid    <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_branch   <= 1'b0;
            mem_dest     <= '0;
        end
    end

    // MEM/WB: always advances. A taken branch moves on as a non-writing op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_dest     <= '0;
        end else begin
            wb_valid    <= mem_valid;
            wb_memtoreg <= mem_memtoreg;
            wb_regwrite <= mem_regwrite;
            wb_dest     <= mem_dest;
        end
    end

    // Event counters hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard. Inputs are driven 1 time unit after a
// rising edge. Outputs are sampled 1-2 time units after that, well away from
// the active edge. The DUT is built with CNT_W=4 so that counter saturation
// can be reached.
module tb_ctrl_pipe_hazard;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_regdst, id_branch, id_memread, id_memtoreg;
    logic          id_memwrite, id_alusrc, id_regwrite;
    logic [1:0]    id_aluop;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          mem_zero;
    logic          stall, flush;
    logic          ex_valid, ex_regdst, ex_memread, ex_memtoreg, ex_memwrite;
    logic          ex_alusrc, ex_regwrite, ex_branch;
    logic [1:0]    ex_aluop;
    logic [AW-1:0] ex_rt, ex_rd;
    logic          mem_valid, mem_memread, mem_memwrite, mem_memtoreg;
    logic          mem_regwrite, mem_branch;
    logic [AW-1:0] mem_dest;
    logic          branch_taken;
    logic          wb_valid, wb_memtoreg, wb_regwrite;
    logic [AW-1:0] wb_dest;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int npass = 0;
    int ntot  = 0;

    ctrl_pipe_hazard #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_regdst(id_regdst), .id_branch(id_branch),
        .id_memread(id_memread), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_aluop(id_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_regdst(ex_regdst), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
        .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_branch(mem_branch),
        .mem_dest(mem_dest), .branch_taken(branch_taken),
        .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit order: valid regdst branch memread memtoreg memwrite alusrc regwrite.
    task automatic drive(input logic [7:0] c, input logic [1:0] op,
                         input int rs, input int rt, input int rd);
        {id_valid, id_regdst, id_branch, id_memread, id_memtoreg,
         id_memwrite, id_alusrc, id_regwrite} = c;
        id_aluop = op;
        id_rs    = AW'(rs);
        id_rt    = AW'(rt);
        id_rd    = AW'(rd);
    endtask

    task automatic rtype(input int rs, input int rt, input int rd);
        drive(8'b1100_0001, 2'b10, rs, rt, rd);
    endtask
    task automatic lw(input int rs, input int rt);
        drive(8'b1001_1011, 2'b00, rs, rt, 0);
    endtask
    task automatic beq(input int rs, input int rt);
        drive(8'b1010_0000, 2'b01, rs, rt, 0);
    endtask
    task automatic nop();
        drive(8'b0000_0000, 2'b00, 0, 0, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        mem_zero = 1'b0;
        nop();
        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_taken", branch_taken, 0);
        chk("rst_cnts", {stall_cnt, flush_cnt}, 0);

        // Load state, then assert reset in the middle of a cycle.
        rst_n = 1'b1;
        rtype(1, 2, 5);
        tick();
        chk("pre_rst_ex_rd", ex_rd, 5);
        tick();
        chk("pre_rst_mem_dest", mem_dest, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_regs", {ex_valid, ex_regwrite, ex_rd, mem_valid,
                               mem_regwrite, mem_dest, wb_valid, wb_dest}, 0);
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_wb_valid_e2", wb_valid, 0);
        tick();
        chk("post_rst_wb", {wb_valid, wb_regwrite, wb_dest}, {1'b1, 1'b1, 5'd5});

        // Load-use hazard: lw r2 followed by add r8 = r2 + r7.
        nop(); tick(); tick(); tick();
        lw(1, 2);
        tick();
        rtype(2, 7, 8);
        #1;
        chk("lu_stall", {stall, flush}, 2'b10);
        tick();
        chk("lu_bubble_ex", ex_valid, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_mem_lw", {mem_valid, mem_memread, mem_regwrite, mem_dest},
            {1'b1, 1'b1, 1'b1, 5'd2});
        chk("lu_no_restall", stall, 0);
        tick();
        chk("lu_add_ex", {ex_valid, ex_regdst, ex_rd}, {1'b1, 1'b1, 5'd8});
        chk("lu_wb_lw", {wb_memtoreg, wb_dest}, {1'b1, 5'd2});
        chk("lu_cnt_hold", stall_cnt, 1);

        // No false hazard: load into r0, then an unrelated register pair.
        nop(); tick();
        lw(1, 0);
        tick();
        rtype(0, 3, 4);
        #1;
        chk("nh_r0_stall", stall, 0);
        tick();
        chk("nh_r0_wr_suppr", {mem_valid, mem_regwrite}, 2'b10);
        lw(1, 4);
        tick();
        rtype(3, 5, 6);
        #1;
        chk("nh_regs_stall", stall, 0);
        tick();

        // A non-valid ID slot becomes a bubble even if control bits are set.
        drive(8'b0100_0001, 2'b10, 1, 2, 9);
        tick();
        chk("idv0_bubble", {ex_valid, ex_regwrite, ex_regdst, ex_rd}, 0);

        // Taken branch in MEM squashes both EX and the instruction behind it.
        nop(); tick(); tick();
        beq(1, 1);
        tick();
        rtype(9, 10, 11);
        tick();
        rtype(12, 13, 14);
        mem_zero = 1'b1;
        #1;
        chk("br_taken", {branch_taken, flush, stall}, 3'b110);
        tick();
        mem_zero = 1'b0;
        chk("br_squash", {ex_valid, mem_valid}, 2'b00);
        chk("br_wb", {wb_valid, wb_regwrite}, 2'b10);
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_flush_clear", flush, 0);

        // Branch not taken.
        beq(1, 2);
        tick();
        rtype(9, 10, 11);
        tick();
        #1;
        chk("bnt_flush", {branch_taken, flush}, 2'b00);
        tick();
        chk("bnt_mem_valid", mem_valid, 1);
        chk("bnt_flush_cnt", flush_cnt, 1);

        // Hazard and taken branch in the same cycle: flush wins.
        beq(3, 3);
        tick();
        lw(1, 6);
        tick();
        rtype(6, 1, 7);
        mem_zero = 1'b1;
        #1;
        chk("sim_flags", {flush, stall}, 2'b10);
        tick();
        mem_zero = 1'b0;
        chk("sim_cnts", {stall_cnt, flush_cnt}, {4'd1, 4'd2});
        chk("sim_squash", {ex_valid, mem_valid}, 2'b00);

        // A self-dependent load stalls every other cycle: 20 stalls in 40
        // cycles. The 4-bit counter must hold at 15.
        lw(2, 2);
        for (int i = 0; i < 40; i++) tick();
        chk("sat_stall_cnt", stall_cnt, 15);
        chk("sat_flush_cnt", flush_cnt, 2);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Consumer side of the instruction decoder's control bundle.
- Carries the decoded control signals and destination register through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards, stalls fetch/decode and inserts bubbles.
- Squashes younger instructions when a branch resolves taken in MEM.
- Sits between the decoder and the EX/MEM/WB datapath.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  decoded control from decoder
- id_aluop  in  2  decoded ALUOp
- id_rs, id_rt, id_rd  in  REG_AW  register fields of the ID instruction
- mem_zero  in  1  ALU zero flag registered into MEM
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  clear IF/ID this cycle
- ex_valid, ex_regdst, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_branch  out  1 each  ID/EX register
- ex_aluop  out  2  ID/EX ALUOp
- ex_rt, ex_rd  out  REG_AW  ID/EX register fields
- mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_branch  out  1 each  EX/MEM register
- mem_dest  out  REG_AW  EX/MEM destination
- branch_taken  out  1  mem_valid & mem_branch & mem_zero (combinational)
- wb_valid, wb_memtoreg, wb_regwrite  out  1 each  MEM/WB register
- wb_dest  out  REG_AW  MEM/WB destination
- stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Reset (rst_n low, asynchronous): every registered output, dest field and counter goes to 0. stall/flush/branch_taken then evaluate to 0 because all valids are 0.
- Latency: a bundle accepted in ID appears on ex_* on the next edge, mem_* one edge later, wb_* one edge after that. No back-pressure from EX onward.
- Bubble: valid=0 and all control bits 0. ex_rt/ex_rd/mem_dest/wb_dest are don't-care but must be driven to 0 in a bubble.
- Destination: EX→MEM edge captures mem_dest = ex_regdst ? ex_rd : ex_rt.
- Write suppression: mem_regwrite is forced to 0 if the computed dest is 0. MEM→WB edge copies mem_dest to wb_dest.
- Load-use hazard (combinational): hazard = id_valid & ex_valid & ex_memread & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt).
- stall = hazard & ~branch_taken.
  - On stall: the ID/EX register loads a bubble. EX/MEM and MEM/WB advance normally.
  - The decoder input is re-presented the following cycle by upstream.
- flush = branch_taken. On flush:
  - ID/EX loads a bubble.
  - EX/MEM loads a bubble, squashing the instruction that was in EX.
  - MEM/WB captures the branch itself normally; it has no regwrite.
- Simultaneous hazard and taken branch: flush wins, stall=0, stall_cnt does not increment.
- id_valid=0 with no flush: ID/EX loads a bubble.
- Counters:
  - stall_cnt += 1 on each cycle with stall=1.
  - flush_cnt += 1 on each cycle with flush=1.
  - Both saturate at all-ones with no wrap.
- Back-to-back loads: lw r2 then lw r3,0(r2) triggers exactly one stall cycle. After the bubble, ex_memread=0 for that slot, so there is no second stall.
- Reset mid-operation: all stages become bubbles immediately. No partial state survives.

Test Plan:
- Reset: drive id_valid=1 with an R-type bundle, then assert rst_n=0 mid-cycle → all outputs 0 asynchronously. After release, first R-type (regdst=1, rd=5) reaches wb_dest=5, wb_regwrite=1 on the 3rd edge.
- Load-use: lw rt=2 in EX, then add rs=2 rt=7 in ID → stall=1 for exactly one cycle, ex_valid=0 the next cycle, stall_cnt=1. The add then proceeds with ex_rs-match cleared.
- No false hazard: lw rt=0 followed by add rs=0 → stall=0. lw rt=4 followed by add rs=3 rt=5 → stall=0.
- Taken branch: beq in MEM with mem_zero=1 → flush=1 and branch_taken=1. Next cycle ex_valid=0 and mem_valid=0, flush_cnt=1. With mem_zero=0 → no flush.
- Simultaneous: load-use hazard present in the same cycle as a taken branch → flush=1, stall=0, stall_cnt unchanged.
- Saturation: force 2^CNT_W+3 stall events (CNT_W=4 build: 19 events) → stall_cnt=15 with no wrap.
